axi_lite_rd_arbiter: RTL and testbench

- Shares one AXI-lite read port (AR/R channels) between the instruction fetch unit (master 0, ibiu side) and the data unit (master 1, dbiu side).
- Sits between the CPU BIUs and the single memory slave in a unified-memory configuration of kiwi_subsys.
- Allows one outstanding read at a time.
- Arbitration is round-robin or fixed-priority; write channels are outside this block.

---
 rtl/axi_lite_rd_arbiter.sv | 85 ++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter: shares one AXI-lite read port (m0/m1 AR+R in, s AR+R out, gnt_o/busy_o status) with one read outstanding
module axi_lite_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic [1:0]        gnt_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t              state_q;
  logic [1:0]          gnt_q;
  logic                last_q;
  logic                s_arvalid_q;
  logic [ADDR_W-1:0]   s_araddr_q;
  logic                idle, in_data, req, pick1;
  assign idle    = state_q == IDLE;
  assign in_data = state_q == DATA;
  assign req     = m0_arvalid | m1_arvalid;
  assign pick1   = (m0_arvalid & m1_arvalid) ? (RR_EN ? ~last_q : 1'b1) : m1_arvalid;
  assign m0_arready = idle & m0_arvalid & ~pick1;
  assign m1_arready = idle & m1_arvalid & pick1;
  assign m0_rvalid  = in_data & gnt_q[0] & s_rvalid;
  assign m1_rvalid  = in_data & gnt_q[1] & s_rvalid;
  assign s_rready   = in_data & ((gnt_q[0] & m0_rready) | (gnt_q[1] & m1_rready));
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;
  assign s_arvalid  = s_arvalid_q;
  assign s_araddr   = s_araddr_q;
  assign gnt_o      = gnt_q;
  assign busy_o     = ~idle;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      s_arvalid_q <= 1'b0;
      s_araddr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          s_araddr_q  <= pick1 ? m1_araddr : m0_araddr;
          gnt_q       <= pick1 ? 2'b10 : 2'b01;
          s_arvalid_q <= 1'b1;
          state_q     <= ADDR;
        end
        ADDR: if (s_arready) begin
          s_arvalid_q <= 1'b0;
          state_q     <= DATA;
        end
        DATA: if (s_rvalid && s_rready) begin
          last_q  <= gnt_q[1];
          gnt_q   <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// tb_axi_lite_rd_arbiter: directed checks of the read arbiter in round-robin and fixed-priority builds
module tb_axi_lite_rd_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_arvalid = 0, m0_rready = 1, m1_arvalid = 0, m1_rready = 1;
  logic [63:0] m0_araddr = 0, m1_araddr = 0, s_rdata = 0;
  logic s_arready = 0, s_rvalid = 0;
  logic [1:0] s_rresp = 0;
  logic m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready, busy_o;
  logic [63:0] m0_rdata, m1_rdata, s_araddr;
  logic [1:0] m0_rresp, m1_rresp, gnt_o;
  logic f_m0_arready, f_m0_rvalid, f_m1_arready, f_m1_rvalid, f_s_arvalid, f_s_rready, f_busy;
  logic [63:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
  logic [1:0] f_m0_rresp, f_m1_rresp, f_gnt;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  axi_lite_rd_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );
  axi_lite_rd_arbiter #(.RR_EN(1'b0)) dut_f (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready), .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready), .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp),
    .s_arvalid(f_s_arvalid), .s_arready(s_arready), .s_araddr(f_s_araddr),
    .s_rvalid(s_rvalid), .s_rready(f_s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .gnt_o(f_gnt), .busy_o(f_busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  task automatic serve(input int m, input logic [63:0] a, input logic [63:0] d, input logic [1:0] r);
    chk("addr_s_arvalid", {63'd0, s_arvalid}, 1);
    chk("addr_s_araddr", s_araddr, a);
    chk("addr_gnt", {62'd0, gnt_o}, m ? 2 : 1);
    chk("addr_arready_low", {62'd0, m0_arready, m1_arready}, 0);
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1;
    s_rdata = d;
    s_rresp = r;
    #1;
    chk("data_s_arvalid_low", {63'd0, s_arvalid}, 0);
    chk("data_rvalid", {62'd0, m1_rvalid, m0_rvalid}, m ? 2 : 1);
    chk("data_rdata", m ? m1_rdata : m0_rdata, d);
    chk("data_rresp", {62'd0, m ? m1_rresp : m0_rresp}, {62'd0, r});
    chk("data_s_rready", {63'd0, s_rready}, 1);
    step();
    s_rvalid = 0;
    #1;
    chk("done_busy", {63'd0, busy_o}, 0);
    chk("done_gnt", {62'd0, gnt_o}, 0);
  endtask
  initial begin
    do_reset();
    #1;
    chk("rst_busy", {63'd0, busy_o}, 0);
    chk("rst_gnt", {62'd0, gnt_o}, 0);
    chk("rst_s_arvalid", {63'd0, s_arvalid}, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 0);
    step();
    m0_arvalid = 1;
    m0_araddr = 64'h1000;
    #1;
    chk("single_m0_arready", {63'd0, m0_arready}, 1);
    chk("single_m1_arready", {63'd0, m1_arready}, 0);
    step();
    m0_arvalid = 0;
    #1;
    chk("single_busy", {63'd0, busy_o}, 1);
    serve(0, 64'h1000, 64'hDEAD_BEEF, 2'b00);
    do_reset();
    m0_arvalid = 1;
    m1_arvalid = 1;
    m0_araddr = 64'h100;
    m1_araddr = 64'h200;
    #1;
    chk("tie_m0_arready", {63'd0, m0_arready}, 1);
    chk("tie_m1_arready", {63'd0, m1_arready}, 0);
    step();
    m0_arvalid = 0;
    #1;
    serve(0, 64'h100, 64'hA0, 2'b00);
    chk("tie_m1_arready_next", {63'd0, m1_arready}, 1);
    step();
    m1_arvalid = 0;
    #1;
    serve(1, 64'h200, 64'hB0, 2'b00);
    do_reset();
    m0_arvalid = 1;
    m1_arvalid = 1;
    s_arready = 1;
    s_rvalid = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_gnt%0d", i), {62'd0, gnt_o}, (i % 2) ? 2 : 1);
      chk($sformatf("fp_gnt%0d", i), {62'd0, f_gnt}, 2);
      step();
      step();
    end
    m1_arvalid = 0;
    step();
    chk("fp_m0_after", {62'd0, f_gnt}, 1);
    m0_arvalid = 0;
    s_arready = 0;
    s_rvalid = 0;
    do_reset();
    m1_arvalid = 1;
    m1_araddr = 64'h300;
    step();
    m1_arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_s_arvalid", {63'd0, s_arvalid}, 1);
      chk("bp_s_araddr", s_araddr, 64'h300);
      step();
    end
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1;
    s_rdata = 64'h55;
    m1_rready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_s_rready", {63'd0, s_rready}, 0);
      chk("bp_m1_rvalid", {63'd0, m1_rvalid}, 1);
      chk("bp_m1_rdata", m1_rdata, 64'h55);
      chk("bp_busy", {63'd0, busy_o}, 1);
      step();
    end
    m1_rready = 1;
    #1;
    chk("bp_s_rready_hi", {63'd0, s_rready}, 1);
    step();
    s_rvalid = 0;
    #1;
    chk("bp_done", {63'd0, busy_o}, 0);
    m0_arvalid = 1;
    m0_araddr = 64'h400;
    step();
    m0_arvalid = 0;
    #1;
    chk("ra_busy", {63'd0, busy_o}, 1);
    rst = 1;
    step();
    rst = 0;
    chk("ra_s_arvalid", {63'd0, s_arvalid}, 0);
    chk("ra_gnt", {62'd0, gnt_o}, 0);
    chk("ra_busy_low", {63'd0, busy_o}, 0);
    m0_arvalid = 1;
    step();
    m0_arvalid = 0;
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1;
    #1;
    chk("rd_in_data", {62'd0, gnt_o}, 1);
    chk("rd_m0_rvalid", {63'd0, m0_rvalid}, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rd_m0_rvalid_low", {63'd0, m0_rvalid}, 0);
    chk("rd_busy_low", {63'd0, busy_o}, 0);
    chk("rd_gnt", {62'd0, gnt_o}, 0);
    s_rvalid = 0;
    m0_arvalid = 1;
    m0_araddr = 64'h500;
    step();
    m0_arvalid = 0;
    #1;
    serve(0, 64'h500, 64'h1234, 2'b10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
